safety_island_fixture: RTL and testbench

- Synthesizable boot/test sequencer that drives the safety island during simulation and emulation.
- Runs a fixed sequence: select boot mode, hold the island in reset, run a bus write/readback sanity test, load a program image, set the entry point, start the core, then poll the end-of-computation (EOC) register.
- Reports exit code and pass/fail.
- Sits between the top-level test control and the island's debug/memory bus port, an OBI-like single-master port.

---
 rtl/safety_island_fixture_pkg.sv | 32 +++
 rtl/safety_island_fixture_bus_master.sv | 80 ++++++++
 rtl/safety_island_fixture.sv | 213 +++++++++++++++++++++
 tb/tb_safety_island_fixture.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/safety_island_fixture_pkg.sv
// rtl/safety_island_fixture_pkg.sv - shared types and default addresses for the safety island fixture
// Contents: boot mode enum, sequencer state enum, counter width, default register map.
package safety_island_fixture_pkg;

    typedef enum logic [1:0] {
        BOOT_INTERNAL  = 2'd0,
        BOOT_JTAG      = 2'd1,
        BOOT_PRELOADED = 2'd2
    } boot_mode_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RESET,
        ST_TEST_WR,
        ST_TEST_RD,
        ST_LOAD,
        ST_SET_ENTRY,
        ST_FETCH_EN,
        ST_POLL_WAIT,
        ST_POLL_RD,
        ST_DONE
    } state_e;

    localparam int unsigned CNT_W = 16;

    localparam logic [31:0] DEF_TEST_ADDR    = 32'h0000_1000;
    localparam logic [31:0] DEF_TEST_DATA    = 32'hABBA_ABBA;
    localparam logic [31:0] DEF_BOOTADDR_REG = 32'h0020_0000;
    localparam logic [31:0] DEF_FETCHEN_REG  = 32'h0020_0004;
    localparam logic [31:0] DEF_EOC_REG      = 32'h0020_0008;

endpackage

// File: rtl/safety_island_fixture_bus_master.sv
// rtl/safety_island_fixture_bus_master.sv - single-outstanding req/gnt/rvalid bus master
// Ports: clk_i/rst_i; start_i/we_i/addr_i/wdata_i issue a transfer when busy_o is low;
// done_o pulses with rdata_o on the response; bus_* is the OBI-like island port.
module safety_island_fixture_bus_master
    import safety_island_fixture_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    logic        req_q, req_d;
    logic        wait_q, wait_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    always_comb begin
        req_d   = req_q;
        wait_d  = wait_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (req_q) begin
            // address phase: hold everything until granted
            if (bus_gnt_i) begin
                req_d  = 1'b0;
                wait_d = 1'b1;
            end
        end else if (wait_q) begin
            if (bus_rvalid_i) begin
                wait_d = 1'b0;
            end
        end else if (start_i) begin
            req_d   = 1'b1;
            we_d    = we_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q   <= 1'b0;
            wait_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            req_q   <= req_d;
            wait_q  <= wait_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // a response with nothing outstanding never reaches done_o
    assign busy_o      = req_q | wait_q;
    assign done_o      = wait_q & bus_rvalid_i;
    assign rdata_o     = bus_rdata_i;
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;

endmodule

// File: rtl/safety_island_fixture.sv
// rtl/safety_island_fixture.sv - boot/test sequencer driving the safety island
// Ports: start_i/boot_mode_i/entry_i start a run; img_* streams the program image;
// boot_mode_o/island_rst_o and bus_* drive the island; busy_o/done_o/test_fail_o/exit_* report.
module safety_island_fixture
    import safety_island_fixture_pkg::*;
#(
    parameter logic [31:0] TEST_ADDR     = DEF_TEST_ADDR,
    parameter logic [31:0] TEST_DATA     = DEF_TEST_DATA,
    parameter logic [31:0] BOOTADDR_REG  = DEF_BOOTADDR_REG,
    parameter logic [31:0] FETCHEN_REG   = DEF_FETCHEN_REG,
    parameter logic [31:0] EOC_REG       = DEF_EOC_REG,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned POLL_INTERVAL = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  boot_mode_i,
    input  logic [31:0] entry_i,
    input  logic        img_valid_i,
    output logic        img_ready_o,
    input  logic [31:0] img_addr_i,
    input  logic [31:0] img_data_i,
    input  logic        img_last_i,
    output logic [1:0]  boot_mode_o,
    output logic        island_rst_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        test_fail_o,
    output logic [31:0] exit_code_o,
    output logic        exit_status_o
);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_INTERVAL - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         boot_mode_q, boot_mode_d;
    logic [31:0]        entry_q, entry_d;
    logic               island_rst_q, island_rst_d;
    logic               issued_q, issued_d;
    logic               last_q, last_d;
    logic               test_fail_q, test_fail_d;
    logic [31:0]        exit_code_q, exit_code_d;
    logic               exit_status_q, exit_status_d;

    logic               bm_start, bm_we, bm_busy, bm_done;
    logic [31:0]        bm_addr, bm_wdata, bm_rdata;

    assign img_ready_o = (state_q == ST_LOAD) && !bm_busy;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        boot_mode_d   = boot_mode_q;
        entry_d       = entry_q;
        island_rst_d  = island_rst_q;
        issued_d      = issued_q;
        last_d        = last_q;
        test_fail_d   = test_fail_q;
        exit_code_d   = exit_code_q;
        exit_status_d = exit_status_q;
        bm_start      = 1'b0;
        bm_we         = 1'b1;
        bm_addr       = TEST_ADDR;
        bm_wdata      = TEST_DATA;

        // fixed-target states fire one transfer on entry and advance on its response
        if (state_q inside {ST_TEST_WR, ST_TEST_RD, ST_SET_ENTRY, ST_FETCH_EN, ST_POLL_RD}) begin
            bm_start = !issued_q;
            issued_d = !bm_done;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    boot_mode_d   = boot_mode_i;
                    entry_d       = entry_i;
                    test_fail_d   = 1'b0;
                    exit_code_d   = 32'h0;
                    exit_status_d = 1'b0;
                    island_rst_d  = 1'b1;
                    cnt_d         = '0;
                    issued_d      = 1'b0;
                    state_d       = ST_RESET;
                end
            end
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    island_rst_d = 1'b0;
                    state_d      = ST_TEST_WR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_TEST_WR: begin
                if (bm_done) state_d = ST_TEST_RD;
            end
            ST_TEST_RD: begin
                bm_we = 1'b0;
                if (bm_done) begin
                    if (bm_rdata != TEST_DATA) test_fail_d = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bm_addr  = img_addr_i;
                bm_wdata = img_data_i;
                bm_start = img_valid_i && img_ready_o;
                if (bm_start) last_d = img_last_i;
                if (bm_done && last_q) state_d = ST_SET_ENTRY;
            end
            ST_SET_ENTRY: begin
                bm_addr  = BOOTADDR_REG;
                bm_wdata = entry_q;
                if (bm_done) state_d = ST_FETCH_EN;
            end
            ST_FETCH_EN: begin
                bm_addr  = FETCHEN_REG;
                bm_wdata = 32'h1;
                if (bm_done) begin
                    cnt_d   = '0;
                    state_d = ST_POLL_WAIT;
                end
            end
            ST_POLL_WAIT: begin
                if (cnt_q == POLL_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_POLL_RD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_POLL_RD: begin
                bm_we   = 1'b0;
                bm_addr = EOC_REG;
                if (bm_done) begin
                    if (bm_rdata[31]) begin
                        exit_code_d   = {1'b0, bm_rdata[30:0]};
                        exit_status_d = (bm_rdata[30:0] == 31'h0);
                        state_d       = ST_DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_POLL_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            boot_mode_q   <= 2'b00;
            entry_q       <= 32'h0;
            island_rst_q  <= 1'b1;
            issued_q      <= 1'b0;
            last_q        <= 1'b0;
            test_fail_q   <= 1'b0;
            exit_code_q   <= 32'h0;
            exit_status_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            boot_mode_q   <= boot_mode_d;
            entry_q       <= entry_d;
            island_rst_q  <= island_rst_d;
            issued_q      <= issued_d;
            last_q        <= last_d;
            test_fail_q   <= test_fail_d;
            exit_code_q   <= exit_code_d;
            exit_status_q <= exit_status_d;
        end
    end

    safety_island_fixture_bus_master u_bus_master (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (bm_start),
        .we_i         (bm_we),
        .addr_i       (bm_addr),
        .wdata_i      (bm_wdata),
        .busy_o       (bm_busy),
        .done_o       (bm_done),
        .rdata_o      (bm_rdata),
        .bus_req_o    (bus_req_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    assign boot_mode_o   = boot_mode_q;
    assign island_rst_o  = island_rst_q;
    assign busy_o        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o        = (state_q == ST_DONE);
    assign test_fail_o   = test_fail_q;
    assign exit_code_o   = exit_code_q;
    assign exit_status_o = exit_status_q;

endmodule

// File: tb/tb_safety_island_fixture.sv
// tb/tb_safety_island_fixture.sv - directed self-checking bench for safety_island_fixture
module tb_safety_island_fixture;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, img_valid_i, img_last_i;
    logic [1:0]  boot_mode_i;
    logic [31:0] entry_i, img_addr_i, img_data_i;
    logic        img_ready_o, island_rst_o, bus_req_o, bus_we_o;
    logic [1:0]  boot_mode_o;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i, exit_code_o;
    logic        bus_gnt_i, bus_rvalid_i, busy_o, done_o, test_fail_o, exit_status_o;

    always #5 clk_i = ~clk_i;

    safety_island_fixture dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .boot_mode_i   (boot_mode_i),
        .entry_i       (entry_i),
        .img_valid_i   (img_valid_i),
        .img_ready_o   (img_ready_o),
        .img_addr_i    (img_addr_i),
        .img_data_i    (img_data_i),
        .img_last_i    (img_last_i),
        .boot_mode_o   (boot_mode_o),
        .island_rst_o  (island_rst_o),
        .bus_req_o     (bus_req_o),
        .bus_gnt_i     (bus_gnt_i),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_rvalid_i  (bus_rvalid_i),
        .bus_rdata_i   (bus_rdata_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .test_fail_o   (test_fail_o),
        .exit_code_o   (exit_code_o),
        .exit_status_o (exit_status_o)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    int          checks = 0;
    int          errors = 0;
    int          gnt_delay = 0;
    int          stable_err = 0;
    logic [31:0] test_rd_data = 32'hABBA_ABBA;
    logic [31:0] eoc_q[$];
    txn_t        log_q[$];

    // island bus model: grant after gnt_delay cycles of request, respond the cycle after grant
    initial begin
        int          wait_cnt;
        logic        gnt_given;
        logic [31:0] rsp, first_addr, first_wdata;
        logic        first_we;
        txn_t        t;
        wait_cnt = 0;
        gnt_given = 1'b0;
        rsp = 32'h0;
        bus_gnt_i = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i = 32'h0;
        forever begin
            @(negedge clk_i);
            bus_rvalid_i = 1'b0;
            if (gnt_given) begin
                gnt_given = 1'b0;
                bus_gnt_i = 1'b0;
                bus_rvalid_i = 1'b1;
                bus_rdata_i = rsp;
            end else if (bus_req_o && !rst_i) begin
                if (wait_cnt == 0) begin
                    first_addr = bus_addr_o;
                    first_wdata = bus_wdata_o;
                    first_we = bus_we_o;
                end else if (bus_addr_o !== first_addr || bus_wdata_o !== first_wdata
                             || bus_we_o !== first_we) begin
                    stable_err++;
                end
                if (wait_cnt == gnt_delay) begin
                    bus_gnt_i = 1'b1;
                    gnt_given = 1'b1;
                    wait_cnt = 0;
                    t.we = bus_we_o;
                    t.addr = bus_addr_o;
                    t.wdata = bus_wdata_o;
                    log_q.push_back(t);
                    rsp = 32'h0;
                    if (!bus_we_o && bus_addr_o == 32'h0020_0008)
                        rsp = (eoc_q.size() > 0) ? eoc_q.pop_front() : 32'h0;
                    else if (!bus_we_o && bus_addr_o == 32'h0000_1000)
                        rsp = test_rd_data;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic start_seq(input logic [1:0] mode, input logic [31:0] entry);
        @(negedge clk_i);
        start_i = 1'b1;
        boot_mode_i = mode;
        entry_i = entry;
        @(negedge clk_i);
        start_i = 1'b0;
        boot_mode_i = 2'd3;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({island_rst_o, busy_o, done_o, bus_req_o, bus_we_o, img_ready_o, test_fail_o, exit_status_o} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 10000000", {island_rst_o, busy_o, done_o, bus_req_o, bus_we_o, img_ready_o, test_fail_o, exit_status_o});
        end
        checks++;
        if ({bus_addr_o, bus_wdata_o, exit_code_o} !== 96'h0) begin
            errors++;
            $display("FAIL reset_words got %h %h %h exp zero", bus_addr_o, bus_wdata_o, exit_code_o);
        end
        checks++;
        if (boot_mode_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_boot_mode got %0d exp 0", boot_mode_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_full_run();
        int   n;
        txn_t exp_t[10];
        log_q.delete();
        gnt_delay = 3;
        test_rd_data = 32'hDEAD_BEEF;
        eoc_q = '{32'h0, 32'h0, 32'h8000_0000};
        stable_err = 0;
        start_seq(2'd1, 32'h1C00_0000);
        checks++;
        if (boot_mode_o !== 2'd1) begin
            errors++;
            $display("FAIL run1_boot_mode got %0d exp 1", boot_mode_o);
        end
        n = 0;
        while (island_rst_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL run1_rst_len got %0d exp 16", n);
        end
        for (int i = 0; i < 3; i++) begin
            img_valid_i = 1'b1;
            img_addr_i = 32'h1C00_0000 + 32'(i * 4);
            img_data_i = 32'h1000_0001 + 32'(i);
            img_last_i = (i == 2);
            n = 0;
            do begin
                @(negedge clk_i);
                n++;
            end while (!img_ready_o && n < 2000);
            checks++;
            if (img_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL run1_img_accept word %0d got ready %b exp 1", i, img_ready_o);
            end
            @(posedge clk_i);
            #1;
        end
        img_valid_i = 1'b0;
        img_last_i = 1'b0;
        n = 0;
        while (done_o !== 1'b1 && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if ({done_o, busy_o, island_rst_o} !== 3'b100) begin
            errors++;
            $display("FAIL run1_done got done/busy/rst %b exp 100", {done_o, busy_o, island_rst_o});
        end
        checks++;
        if (test_fail_o !== 1'b1) begin
            errors++;
            $display("FAIL run1_test_fail got %b exp 1", test_fail_o);
        end
        checks++;
        if (exit_code_o !== 32'h0 || exit_status_o !== 1'b1) begin
            errors++;
            $display("FAIL run1_exit got %h/%b exp 00000000/1", exit_code_o, exit_status_o);
        end
        checks++;
        if (stable_err != 0) begin
            errors++;
            $display("FAIL run1_addr_stable got %0d changes exp 0", stable_err);
        end
        checks++;
        if (log_q.size() != 10) begin
            errors++;
            $display("FAIL run1_txn_count got %0d exp 10", log_q.size());
        end
        exp_t[0] = '{1'b1, 32'h0000_1000, 32'hABBA_ABBA};
        exp_t[1] = '{1'b0, 32'h0000_1000, 32'h0};
        exp_t[2] = '{1'b1, 32'h1C00_0000, 32'h1000_0001};
        exp_t[3] = '{1'b1, 32'h1C00_0004, 32'h1000_0002};
        exp_t[4] = '{1'b1, 32'h1C00_0008, 32'h1000_0003};
        exp_t[5] = '{1'b1, 32'h0020_0000, 32'h1C00_0000};
        exp_t[6] = '{1'b1, 32'h0020_0004, 32'h0000_0001};
        exp_t[7] = '{1'b0, 32'h0020_0008, 32'h0};
        exp_t[8] = '{1'b0, 32'h0020_0008, 32'h0};
        exp_t[9] = '{1'b0, 32'h0020_0008, 32'h0};
        for (int i = 0; i < 10; i++) begin
            if (i < log_q.size()) begin
                checks++;
                if (log_q[i].we !== exp_t[i].we || log_q[i].addr !== exp_t[i].addr
                    || (exp_t[i].we && log_q[i].wdata !== exp_t[i].wdata)) begin
                    errors++;
                    $display("FAIL run1_txn %0d got we=%b a=%h d=%h exp we=%b a=%h d=%h", i,
                             log_q[i].we, log_q[i].addr, log_q[i].wdata,
                             exp_t[i].we, exp_t[i].addr, exp_t[i].wdata);
                end
            end
        end
    endtask

    task automatic test_restart_nonzero_exit();
        int n;
        log_q.delete();
        gnt_delay = 0;
        test_rd_data = 32'hABBA_ABBA;
        eoc_q = '{32'h8000_0005};
        start_seq(2'd2, 32'h1C00_0100);
        checks++;
        if ({done_o, busy_o, boot_mode_o} !== 4'b0110) begin
            errors++;
            $display("FAIL run2_restart got done/busy/mode %b exp 0110", {done_o, busy_o, boot_mode_o});
        end
        n = 0;
        while (island_rst_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL run2_rst_len got %0d exp 16", n);
        end
        start_seq(2'd0, 32'hFFFF_FFFF);
        @(negedge clk_i);
        checks++;
        if (island_rst_o !== 1'b0 || boot_mode_o !== 2'd2) begin
            errors++;
            $display("FAIL run2_start_ignored got rst=%b mode=%0d exp 0/2", island_rst_o, boot_mode_o);
        end
        img_valid_i = 1'b1;
        img_addr_i = 32'h1C00_0100;
        img_data_i = 32'h5555_AAAA;
        img_last_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!img_ready_o && n < 2000);
        @(posedge clk_i);
        #1;
        img_valid_i = 1'b0;
        img_last_i = 1'b0;
        n = 0;
        while (done_o !== 1'b1 && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (done_o !== 1'b1 || exit_code_o !== 32'h5 || exit_status_o !== 1'b0) begin
            errors++;
            $display("FAIL run2_exit got done=%b code=%h st=%b exp 1/00000005/0", done_o, exit_code_o, exit_status_o);
        end
        checks++;
        if (test_fail_o !== 1'b0) begin
            errors++;
            $display("FAIL run2_test_fail got %b exp 0", test_fail_o);
        end
        checks++;
        if (log_q.size() != 6 || log_q[3].addr !== 32'h0020_0000 || log_q[3].wdata !== 32'h1C00_0100) begin
            errors++;
            $display("FAIL run2_entry_write got n=%0d", log_q.size());
        end
    endtask

    task automatic test_reset_in_load();
        int n;
        gnt_delay = 0;
        test_rd_data = 32'hABBA_ABBA;
        start_seq(2'd0, 32'h0);
        n = 0;
        while (img_ready_o !== 1'b1 && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (img_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL load_reached got ready %b exp 1", img_ready_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({img_ready_o, island_rst_o, busy_o, done_o, bus_req_o} !== 5'b01000) begin
            errors++;
            $display("FAIL load_reset got ready/rst/busy/done/req %b exp 01000", {img_ready_o, island_rst_o, busy_o, done_o, bus_req_o});
        end
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        checks++;
        if ({img_ready_o, island_rst_o, busy_o, bus_req_o} !== 4'b0100) begin
            errors++;
            $display("FAIL load_idle_after got ready/rst/busy/req %b exp 0100", {img_ready_o, island_rst_o, busy_o, bus_req_o});
        end
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        boot_mode_i = 2'd0;
        entry_i = 32'h0;
        img_valid_i = 1'b0;
        img_addr_i = 32'h0;
        img_data_i = 32'h0;
        img_last_i = 1'b0;
        test_reset();
        test_full_run();
        test_restart_nonzero_exit();
        test_reset_in_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
